// File: rtl/hypot_iter_if.sv
// Handshake bundle for the hypot_iter engine: operand request channel,
// result response channel and the busy status flag.
interface hypot_iter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   hyp;
    logic             busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, hyp, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, hyp, busy
    );
endinterface

// File: rtl/hypot_iter.sv
// Multi-cycle hypotenuse engine: floor(sqrt(x*x + y*y)) via shift-add squaring
// and a restoring square root. Define HYPOT_ROUND_EN to round to nearest instead.
module hypot_iter #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    hypot_iter_if.slave bus
);
    localparam int AW = 2*WIDTH + 2;
    localparam int RW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_SQ = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_RT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

`ifdef HYPOT_ROUND_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SQX   = 3'd1,
        ST_SQY   = 3'd2,
        ST_ROOT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ROUND = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SQX   = 3'd1,
        ST_SQY   = 3'd2,
        ST_ROOT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`endif

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] op_r;
    logic [WIDTH-1:0] y_r;
    logic [AW-1:0]    mcand_r;
    logic [AW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic [RW-1:0]    rem_r;
    logic [WIDTH:0]   root_r;
    logic [WIDTH:0]   hyp_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;

    logic             accept_s;
    logic             release_s;
    logic [RW+1:0]    shifted_s;
    logic [RW+1:0]    root_sub_s;
    logic [RW+1:0]    trial_s;
    logic             trial_ok_s;
    logic [RW-1:0]    rem_nx_s;
    logic [WIDTH:0]   root_nx_s;
    logic             unused_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.hyp       = hyp_r;
    assign bus.busy      = busy_r;

    assign accept_s  = (state_r == ST_IDLE) && bus.in_valid && in_ready_r;
    assign release_s = (state_r == ST_DONE) && out_valid_r && bus.out_ready;

    // One restoring root step: bring down the next radicand pair, try subtracting 4*root+1.
    always_comb begin
        shifted_s  = {rem_r, acc_r[AW-1 -: 2]};
        root_sub_s = {2'b00, root_r, 2'b01};
        trial_s    = shifted_s - root_sub_s;
        trial_ok_s = (shifted_s >= root_sub_s);
        if (trial_ok_s) begin
            rem_nx_s = trial_s[RW-1:0];
        end else begin
            rem_nx_s = shifted_s[RW-1:0];
        end
        root_nx_s = {root_r[WIDTH-1:0], trial_ok_s};
    end

    // Remainder stays below 2^(WIDTH+2), so the top bits of the step arithmetic are always zero.
    assign unused_s = ^{shifted_s[RW+1:RW], trial_s[RW+1:RW], root_r[WIDTH]};

    // Next-state selection for the sequencing FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_SQX;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SQX: begin
                if (cnt_r == LAST_SQ) begin
                    state_nx_s = ST_SQY;
                end else begin
                    state_nx_s = ST_SQX;
                end
            end
            ST_SQY: begin
                if (cnt_r == LAST_SQ) begin
                    state_nx_s = ST_ROOT;
                end else begin
                    state_nx_s = ST_SQY;
                end
            end
            ST_ROOT: begin
                if (cnt_r == LAST_RT) begin
`ifdef HYPOT_ROUND_EN
                    state_nx_s = ST_ROUND;
`else
                    state_nx_s = ST_DONE;
`endif
                end else begin
                    state_nx_s = ST_ROOT;
                end
            end
`ifdef HYPOT_ROUND_EN
            ST_ROUND: begin
                state_nx_s = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (release_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: operand latch, squaring accumulator, root iteration and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= '0;
            y_r         <= '0;
            mcand_r     <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            rem_r       <= '0;
            root_r      <= '0;
            hyp_r       <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r    <= bus.x;
                        y_r     <= bus.y;
                        mcand_r <= {{(AW-WIDTH){1'b0}}, bus.x};
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        rem_r   <= '0;
                        root_r  <= '0;
                    end
                end
                ST_SQX, ST_SQY: begin
                    // op_r walks the multiplier bits LSB first while mcand_r tracks operand << step.
                    if (op_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    if (cnt_r == LAST_SQ) begin
                        cnt_r   <= '0;
                        op_r    <= y_r;
                        mcand_r <= {{(AW-WIDTH){1'b0}}, y_r};
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        op_r    <= op_r >> 1;
                        mcand_r <= mcand_r << 1;
                    end
                end
                ST_ROOT: begin
                    acc_r  <= acc_r << 2;
                    rem_r  <= rem_nx_s;
                    root_r <= root_nx_s;
                    if (cnt_r == LAST_RT) begin
                        cnt_r <= '0;
`ifndef HYPOT_ROUND_EN
                        hyp_r       <= root_nx_s;
                        out_valid_r <= 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef HYPOT_ROUND_EN
                ST_ROUND: begin
                    // sqrt(N) >= root + 1/2 exactly when the integer remainder exceeds root.
                    if (rem_r > {2'b00, root_r}) begin
                        hyp_r <= root_r + {{WIDTH{1'b0}}, 1'b1};
                    end else begin
                        hyp_r <= root_r;
                    end
                    out_valid_r <= 1'b1;
                end
`endif
                ST_DONE: begin
                    if (release_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
            in_ready_r <= (state_nx_s == ST_IDLE);
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_hypot_iter.sv
// Directed and model-checked bench for hypot_iter at WIDTH=8 and WIDTH=12.
module tb_hypot_iter;
`ifdef HYPOT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int LAT8  = 3*8  + 1 + (RND ? 1 : 0);
    localparam int LAT12 = 3*12 + 1 + (RND ? 1 : 0);

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    hypot_iter_if #(.WIDTH(8))  b8 ();
    hypot_iter_if #(.WIDTH(12)) b12 ();

    hypot_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    hypot_iter #(.WIDTH(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint ref_hyp(input longint a, input longint b, input bit rnd);
        longint n;
        longint r;
        n = a*a + b*b;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        if (rnd && ((n - r*r) > r)) r++;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run8(input int xv, input int yv, input longint expv, input string tag);
        int lat;
        int w;
        w = 0;
        while (!b8.in_ready && w < 200) begin tick(); w++; end
        b8.x        = 8'(xv);
        b8.y        = 8'(yv);
        b8.in_valid = 1'b1;
        b8.out_ready = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 200) begin tick(); lat++; end
        check({tag, " latency"}, 64'(lat), 64'(LAT8));
        check({tag, " hyp"}, 64'(b8.hyp), 64'(expv));
        tick();
        check({tag, " out_valid drop"}, 64'(b8.out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(b8.in_ready), 64'd1);
    endtask

    task automatic run12(input int xv, input int yv, input longint expv, input string tag);
        int lat;
        int w;
        w = 0;
        while (!b12.in_ready && w < 200) begin tick(); w++; end
        b12.x        = 12'(xv);
        b12.y        = 12'(yv);
        b12.in_valid = 1'b1;
        b12.out_ready = 1'b1;
        tick();
        b12.in_valid = 1'b0;
        lat = 0;
        while (!b12.out_valid && lat < 200) begin tick(); lat++; end
        check({tag, " latency"}, 64'(lat), 64'(LAT12));
        check({tag, " hyp"}, 64'(b12.hyp), 64'(expv));
        tick();
        check({tag, " in_ready back"}, 64'(b12.in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        int xv;
        int yv;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        b8.in_valid = 1'b0;  b8.x = 8'd0;   b8.y = 8'd0;   b8.out_ready = 1'b0;
        b12.in_valid = 1'b0; b12.x = 12'd0; b12.y = 12'd0; b12.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst in_ready", 64'(b8.in_ready), 64'd1);
        check("rst out_valid", 64'(b8.out_valid), 64'd0);
        check("rst hyp", 64'(b8.hyp), 64'd0);
        check("rst busy", 64'(b8.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        run8(3, 4, 5, "3_4");
        run8(255, 255, RND ? 361 : 360, "255_255");
        run8(0, 0, 0, "0_0");
        run8(2, 3, RND ? 4 : 3, "2_3");
        run8(5, 5, 7, "5_5");

        // Back-pressure: result must hold while out_ready is low; a new request is ignored.
        b8.x = 8'd6; b8.y = 8'd8; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        tick();
        b8.in_valid = 1'b0;
        b8.x = 8'd0; b8.y = 8'd0;
        lat = 0;
        while (!b8.out_valid && lat < 200) begin tick(); lat++; end
        check("hold latency", 64'(lat), 64'(LAT8));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin b8.in_valid = 1'b1; b8.x = 8'd1; b8.y = 8'd1; end
            if (i == 4) b8.in_valid = 1'b0;
            check("hold hyp", 64'(b8.hyp), 64'd10);
            check("hold out_valid", 64'(b8.out_valid), 64'd1);
            check("hold in_ready", 64'(b8.in_ready), 64'd0);
            tick();
        end
        b8.out_ready = 1'b1;
        tick();
        check("hold release out_valid", 64'(b8.out_valid), 64'd0);
        check("hold release in_ready", 64'(b8.in_ready), 64'd1);
        tick(); tick(); tick();
        check("ignored pulse busy", 64'(b8.busy), 64'd0);
        check("ignored pulse out_valid", 64'(b8.out_valid), 64'd0);
        run8(1, 1, 1, "1_1");

        // Reset in the middle of a computation abandons it.
        b8.x = 8'd200; b8.y = 8'd100; b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        repeat (11) tick();
        check("mid busy before rst", 64'(b8.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst in_ready", 64'(b8.in_ready), 64'd1);
        check("mid rst out_valid", 64'(b8.out_valid), 64'd0);
        check("mid rst hyp", 64'(b8.hyp), 64'd0);
        check("mid rst busy", 64'(b8.busy), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            tick();
            if (b8.out_valid) seen++;
        end
        check("abandoned result", 64'(seen), 64'd0);
        run8(9, 12, 15, "9_12");

        for (int i = 0; i < 500; i++) begin
            xv = int'($urandom_range(0, 255));
            yv = int'($urandom_range(0, 255));
            run8(xv, yv, ref_hyp(longint'(xv), longint'(yv), RND), "sweep8");
        end
        run12(4095, 4095, ref_hyp(64'd4095, 64'd4095, RND), "12_max");
        for (int i = 0; i < 500; i++) begin
            xv = int'($urandom_range(0, 4095));
            yv = int'($urandom_range(0, 4095));
            run12(xv, yv, ref_hyp(longint'(xv), longint'(yv), RND), "sweep12");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hypot_iter.md
Name: hypot_iter

Overview:
- Parametrised, multi-cycle hypotenuse engine. Computes floor(sqrt(x*x + y*y)) for unsigned WIDTH-bit operands.
- Uses shift-add squaring and digit-by-digit (restoring) square root. No multiplier and no combinational loops.
- Successor to the single-cycle 8-bit Pythagoras block. Adds generic width, a full-width (WIDTH+1-bit) result with no truncation, and valid/ready handshakes on input and output.
- Sits between operand producers and downstream consumers on the project datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2. Result width is WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair x/y is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- x  input  WIDTH  operand x, unsigned.
- y  input  WIDTH  operand y, unsigned.
- out_valid  output  1  hyp holds a completed result.
- out_ready  input  1  consumer accepts the result.
- hyp  output  WIDTH+1  result, unsigned.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; in_ready=1; out_valid=0; hyp=0; busy=0.
  - All internal registers cleared.
  - Reset mid-operation abandons the computation; no result is ever emitted for it.
- States: IDLE, SQX, SQY, ROOT, DONE (plus ROUND only when HYPOT_ROUND_EN is defined).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch x and y, clear the (2*WIDTH+2)-bit accumulator, clear the step counter, go to SQX.
- SQX, WIDTH cycles:
  - Step i: if x[i] is set, add (x << i) to the accumulator.
  - After step WIDTH-1, go to SQY.
- SQY, WIDTH cycles: same rule with y, added into the same accumulator.
- ROOT, WIDTH+1 cycles:
  - Restoring digit-by-digit square root of the (2*WIDTH+2)-bit accumulator, two radicand bits per cycle, MSB pair first.
  - Registers: remainder (WIDTH+3 bits) and root (WIDTH+1 bits).
  - Each step: trial = (rem<<2 | next pair) - (root<<2 | 1).
  - If trial >= 0: rem = trial and root = root<<1 | 1. Otherwise rem = the shifted value and root = root<<1.
  - After the last step, load hyp with root, set out_valid=1, go to DONE.
- DONE:
  - hyp and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready at an edge: out_valid=0, go to IDLE.
  - hyp keeps its last value until the next result overwrites it.
- Latency:
  - Accept at edge k gives out_valid high after edge k+3*WIDTH+1 (25 cycles for WIDTH=8).
  - Minimum issue interval is 3*WIDTH+3 cycles.
- in_ready=0 in every state except IDLE. in_valid asserted while busy is ignored; no queuing.
- Simultaneous out_ready and in_valid in DONE: only the result is consumed. The new operand is accepted no earlier than the next cycle, in IDLE.
- x or y changing after acceptance has no effect; the operands are latched at accept.
- Width rule:
  - x^2+y^2 <= 2*(2^WIDTH-1)^2 < 2^(2*WIDTH+1), so the accumulator never overflows.
  - sqrt of that bound < 2^(WIDTH+1), so hyp never truncates.
- Zero operands take the full latency (no early exit), keeping latency constant.

Optional Feature:
- Macro: HYPOT_ROUND_EN.
- Defined:
  - One extra ROUND state follows ROOT.
  - If final remainder > root, hyp = root+1; otherwise hyp = root. This gives round-to-nearest of the true root.
  - Latency becomes 3*WIDTH+2 cycles. The result still fits in WIDTH+1 bits.
- Not defined: no ROUND state; hyp = floor of the root; latency 3*WIDTH+1.

Test Plan:
- WIDTH=8, x=3, y=4, out_ready=1 -> out_valid rises exactly 25 cycles after accept; hyp=5; in_ready returns high the cycle after the handshake.
- x=255, y=255 -> hyp=360 (361 with HYPOT_ROUND_EN); confirms no truncation to 8 bits.
- x=0, y=0 -> hyp=0 after full latency. Also x=2, y=3 -> hyp=3 (4 with HYPOT_ROUND_EN). Also x=5, y=5 -> hyp=7 in both builds.
- x=6, y=8, out_ready held low 10 cycles after out_valid -> hyp=10 stable throughout; in_ready=0; a new in_valid pulse (x=1, y=1) during this time is ignored. Then out_ready=1 -> one handshake, IDLE; a fresh request x=1, y=1 gives hyp=1.
- Accept x=200, y=100, assert rst_n=0 at cycle 12 for 2 cycles -> outputs return to reset values immediately; no out_valid follows. After release, x=9, y=12 -> hyp=15.
- Back-to-back random sweep (WIDTH=8 and WIDTH=12, 500 pairs each) -> every hyp matches the reference model floor(sqrt(x^2+y^2)) (rounded in the HYPOT_ROUND_EN build); latency constant for every transaction.
